// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: stage-register advance/hold/bubble
// control from data hazards, taken branches and multi-cycle SRAM accesses,
// plus saturating stall and flush counters for performance debug.
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_WAIT = 3,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fwd_en,
    input  logic [3:0]       id_src1,
    input  logic [3:0]       id_src2,
    input  logic             id_two_src,
    input  logic [3:0]       exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [3:0]       mem_dest,
    input  logic             mem_wb_en,
    input  logic             exe_branch,
    input  logic             mem_r_en,
    input  logic             mem_w_en,
    output logic             pc_freeze,
    output logic             if_id_freeze,
    output logic             if_id_flush,
    output logic             id_exe_clr,
    output logic             pipe_freeze,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {StRun, StWait, StRelease} mem_state_e;

    localparam bit         HasWait  = (MEM_WAIT != 0);
    localparam bit         OneWait  = (MEM_WAIT == 1);
    localparam logic [3:0] WaitInit = 4'(MEM_WAIT - 1);

    mem_state_e       state_q;
    logic [3:0]       wcnt_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    logic mem_acc;
    logic freeze_req;
    logic exe_match;
    logic mem_match;
    logic hazard;
    logic stall_inc;
    logic flush_inc;

    assign mem_acc   = mem_r_en | mem_w_en;
    assign exe_match = (id_src1 == exe_dest) | (id_two_src & (id_src2 == exe_dest));
    assign mem_match = (id_src1 == mem_dest) | (id_two_src & (id_src2 == mem_dest));

    // With forwarding only a load in EXE can't be bypassed (load-use).
    assign hazard = fwd_en ? (exe_mem_r_en & exe_match)
                           : ((exe_wb_en & exe_match) | (mem_wb_en & mem_match));

    // RELEASE ignores the access request so the frozen access can leave MEM.
    assign freeze_req = ((state_q == StRun) & mem_acc & HasWait) | (state_q == StWait);

    // Memory wait FSM: counts down the frozen cycles of one SRAM access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
            wcnt_q  <= 4'd0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (mem_acc && HasWait) begin
                        wcnt_q  <= WaitInit;
                        state_q <= OneWait ? StRelease : StWait;
                    end
                end
                StWait: begin
                    wcnt_q <= wcnt_q - 4'd1;
                    if (wcnt_q == 4'd1) begin
                        state_q <= StRelease;
                    end
                end
                StRelease: state_q <= StRun;
                default:   state_q <= StRun;
            endcase
        end
    end

    // Prioritised control outputs: memory freeze, then branch flush, then hazard bubble.
    always_comb begin
        pc_freeze    = 1'b0;
        if_id_freeze = 1'b0;
        if_id_flush  = 1'b0;
        id_exe_clr   = 1'b0;
        pipe_freeze  = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        if (rst) begin
            // all outputs held low during reset
        end else if (freeze_req) begin
            // EXE is held, so any branch or hazard is seen again next cycle
            pipe_freeze  = 1'b1;
            pc_freeze    = 1'b1;
            if_id_freeze = 1'b1;
        end else if (exe_branch) begin
            if_id_flush = 1'b1;
            id_exe_clr  = 1'b1;
            flush_inc   = 1'b1;
        end else if (hazard) begin
            pc_freeze    = 1'b1;
            if_id_freeze = 1'b1;
            id_exe_clr   = 1'b1;
            stall_inc    = 1'b1;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_inc && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (flush_inc && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: table of combinational hazard/branch
// vectors plus hand sequences for SRAM waits, reset mid-wait and saturation.
module tb_pipe_hazard_ctrl;

    typedef struct {
        string      name;
        logic       fwd;
        logic [3:0] s1;
        logic [3:0] s2;
        logic       two;
        logic [3:0] ed;
        logic       ewb;
        logic       elr;
        logic [3:0] md;
        logic       mwb;
        logic       br;
        logic       e_pcf;
        logic       e_iff;
        logic       e_flush;
        logic       e_clr;
        logic       e_pf;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fwd_en, id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en, exe_branch;
    logic mem_r_en, mem_w_en;
    logic [3:0] id_src1, id_src2, exe_dest, mem_dest;

    logic pc_freeze, if_id_freeze, if_id_flush, id_exe_clr, pipe_freeze;
    logic [15:0] stall_cnt, flush_cnt;
    logic nw_pcf, nw_iff, nw_flush, nw_clr, nw_pf;
    logic [15:0] nw_stall, nw_flushc;
    logic st_pcf, st_iff, st_flush, st_clr, st_pf;
    logic [3:0] st_stall, st_flushc;

    int n_vec = 0;
    int n_err = 0;
    int exp_stall = 0;
    int exp_flush = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_WAIT(3), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .fwd_en(fwd_en), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
        .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .exe_branch(exe_branch), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .pc_freeze(pc_freeze), .if_id_freeze(if_id_freeze), .if_id_flush(if_id_flush),
        .id_exe_clr(id_exe_clr), .pipe_freeze(pipe_freeze), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    pipe_hazard_ctrl #(.MEM_WAIT(0), .CNT_W(16)) u_dut_nw (
        .clk(clk), .rst(rst), .fwd_en(fwd_en), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
        .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .exe_branch(exe_branch), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .pc_freeze(nw_pcf), .if_id_freeze(nw_iff), .if_id_flush(nw_flush),
        .id_exe_clr(nw_clr), .pipe_freeze(nw_pf), .stall_cnt(nw_stall),
        .flush_cnt(nw_flushc)
    );

    pipe_hazard_ctrl #(.MEM_WAIT(3), .CNT_W(4)) u_dut_sat (
        .clk(clk), .rst(rst), .fwd_en(fwd_en), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
        .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .exe_branch(exe_branch), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .pc_freeze(st_pcf), .if_id_freeze(st_iff), .if_id_flush(st_flush),
        .id_exe_clr(st_clr), .pipe_freeze(st_pf), .stall_cnt(st_stall),
        .flush_cnt(st_flushc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic fwd, input logic [3:0] s1,
                                input logic [3:0] s2, input logic two, input logic [3:0] ed,
                                input logic ewb, input logic elr, input logic [3:0] md,
                                input logic mwb, input logic br, input logic e_pcf,
                                input logic e_iff, input logic e_flush, input logic e_clr,
                                input logic e_pf);
        vec_t v;
        v.name = name; v.fwd = fwd; v.s1 = s1; v.s2 = s2; v.two = two; v.ed = ed;
        v.ewb = ewb; v.elr = elr; v.md = md; v.mwb = mwb; v.br = br;
        v.e_pcf = e_pcf; v.e_iff = e_iff; v.e_flush = e_flush; v.e_clr = e_clr;
        v.e_pf = e_pf;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        fwd_en = v.fwd; id_src1 = v.s1; id_src2 = v.s2; id_two_src = v.two;
        exe_dest = v.ed; exe_wb_en = v.ewb; exe_mem_r_en = v.elr;
        mem_dest = v.md; mem_wb_en = v.mwb; exe_branch = v.br;
    endtask

    task automatic quiet();
        fwd_en = 0; id_src1 = 0; id_src2 = 0; id_two_src = 0; exe_dest = 0;
        exe_wb_en = 0; exe_mem_r_en = 0; mem_dest = 0; mem_wb_en = 0;
        exe_branch = 0; mem_r_en = 0; mem_w_en = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] pat;
        vec_t hz;

        //        name          fwd s1 s2 two ed ewb elr md mwb br  pcf iff fl clr pf
        vq.push_back(mk("load_use",    1, 4, 0, 0, 4, 1, 1, 0, 0, 0,  1, 1, 0, 1, 0));
        vq.push_back(mk("load_nouse",  1, 5, 0, 0, 4, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0));
        vq.push_back(mk("alu_fwd",     1, 4, 0, 0, 4, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0));
        vq.push_back(mk("nofwd_mem2",  0, 0, 7, 1, 0, 0, 0, 7, 1, 0,  1, 1, 0, 1, 0));
        vq.push_back(mk("nofwd_one",   0, 0, 7, 0, 0, 0, 0, 7, 1, 0,  0, 0, 0, 0, 0));
        vq.push_back(mk("nofwd_exe",   0, 3, 0, 0, 3, 1, 0, 0, 0, 0,  1, 1, 0, 1, 0));
        vq.push_back(mk("load_src2",   1, 2, 9, 1, 9, 1, 1, 0, 0, 0,  1, 1, 0, 1, 0));
        vq.push_back(mk("load_src2x",  1, 2, 9, 0, 9, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0));
        vq.push_back(mk("br_over_hz",  1, 4, 0, 0, 4, 1, 1, 0, 0, 1,  0, 0, 1, 1, 0));
        vq.push_back(mk("br_alone",    0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 1, 0));
        vq.push_back(mk("nofwd_nowb",  0, 7, 0, 0, 0, 0, 0, 7, 0, 0,  0, 0, 0, 0, 0));
        vq.push_back(mk("fwd_mem",     1, 7, 0, 0, 0, 0, 0, 7, 1, 0,  0, 0, 0, 0, 0));

        quiet();
        exe_branch = 1'b1;
        #2;
        check("rst_flush", 32'(if_id_flush), 0);
        check("rst_clr", 32'(id_exe_clr), 0);
        check("rst_stall_cnt", 32'(stall_cnt), 0);
        check("rst_flush_cnt", 32'(flush_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        quiet();

        // Table: combinational outputs, then counters after the edge.
        foreach (vq[i]) begin
            @(negedge clk);
            apply(vq[i]);
            #2;
            check({vq[i].name, ".pc_freeze"}, 32'(pc_freeze), 32'(vq[i].e_pcf));
            check({vq[i].name, ".if_id_freeze"}, 32'(if_id_freeze), 32'(vq[i].e_iff));
            check({vq[i].name, ".if_id_flush"}, 32'(if_id_flush), 32'(vq[i].e_flush));
            check({vq[i].name, ".id_exe_clr"}, 32'(id_exe_clr), 32'(vq[i].e_clr));
            check({vq[i].name, ".pipe_freeze"}, 32'(pipe_freeze), 32'(vq[i].e_pf));
            if (vq[i].e_flush) exp_flush++;
            else if (vq[i].e_clr) exp_stall++;
            @(posedge clk);
            #1;
            check({vq[i].name, ".stall_cnt"}, 32'(stall_cnt), 32'(exp_stall));
            check({vq[i].name, ".flush_cnt"}, 32'(flush_cnt), 32'(exp_flush));
        end

        // Reset during WAIT (counters are nonzero from the table).
        @(negedge clk);
        quiet();
        mem_r_en = 1'b1;
        #2;
        check("rw_freeze1", 32'(pipe_freeze), 1);
        @(negedge clk);
        #2;
        check("rw_freeze2", 32'(pipe_freeze), 1);
        rst = 1'b1;
        exe_branch = 1'b1;
        #1;
        check("rw_pipe_freeze", 32'(pipe_freeze), 0);
        check("rw_pc_freeze", 32'(pc_freeze), 0);
        check("rw_if_id_freeze", 32'(if_id_freeze), 0);
        check("rw_flush", 32'(if_id_flush), 0);
        check("rw_clr", 32'(id_exe_clr), 0);
        check("rw_stall_cnt", 32'(stall_cnt), 0);
        check("rw_flush_cnt", 32'(flush_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        quiet();
        #2;
        check("rw_run_no_freeze", 32'(pipe_freeze), 0);
        @(negedge clk);
        #2;
        check("rw_run_no_freeze2", 32'(pipe_freeze), 0);

        // Two back-to-back SRAM reads; a branch during a frozen cycle is deferred.
        do_reset();
        quiet();
        pat = 8'b0111_0111;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) @(negedge clk);
            mem_r_en = 1'b1;
            exe_branch = (i == 1);
            #2;
            check($sformatf("sram_pf[%0d]", i), 32'(pipe_freeze), 32'(pat[i]));
            check($sformatf("sram_pcf[%0d]", i), 32'(pc_freeze), 32'(pat[i]));
            check($sformatf("sram_nowait_pf[%0d]", i), 32'(nw_pf), 0);
            if (i == 1) check("sram_branch_deferred", 32'(if_id_flush), 0);
        end
        @(negedge clk);
        quiet();
        #2;
        check("sram_flush_cnt", 32'(flush_cnt), 0);

        // Saturation: 20 consecutive load-use cycles.
        do_reset();
        hz = vq[0];
        apply(hz);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
        end
        #2;
        check("sat_stall_4bit", 32'(st_stall), 15);
        check("sat_stall_16bit", 32'(stall_cnt), 20);
        check("sat_still_stalling", 32'(st_clr), 1);
        quiet();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central pipeline sequencer for the 5-stage ARM core. It decides each cycle whether the IF/ID, ID/EXE, EXE/MEM and MEM/WB stage registers advance, hold, or load a bubble. Three conditions drive it: data hazards (with and without forwarding), branches taken in EXE, and multi-cycle SRAM accesses in MEM. It also keeps saturating stall and flush counters for performance debug.

## Interface
Parameters:
- MEM_WAIT, 3, number of freeze cycles per SRAM access in MEM, legal range 0..15; 0 means single-cycle memory.
- CNT_W, 16, width of the performance counters.

Ports (clock and reset per already-decided convention: reset rst, asynchronous, active-high; clock clk):
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- fwd_en  in  1  forwarding unit enabled
- id_src1  in  4  Rn of the instruction in ID
- id_src2  in  4  second source (Rm or Rd for STR) of the instruction in ID
- id_two_src  in  1  id_src2 is actually read
- exe_dest  in  4  destination of the instruction in EXE
- exe_wb_en  in  1  EXE instruction writes back
- exe_mem_r_en  in  1  EXE instruction is a load
- mem_dest  in  4  destination of the instruction in MEM
- mem_wb_en  in  1  MEM instruction writes back
- exe_branch  in  1  branch taken, resolved in EXE
- mem_r_en, mem_w_en  in  1 each  MEM stage performs an SRAM read or write
- pc_freeze  out  1  hold PC
- if_id_freeze  out  1  hold the IF/ID register
- if_id_flush  out  1  clear the IF/ID register
- id_exe_clr  out  1  load a bubble into the ID/EXE register (its clr input)
- pipe_freeze  out  1  hold the ID/EXE, EXE/MEM and MEM/WB registers and PC
- stall_cnt  out  CNT_W  hazard bubbles inserted, saturating
- flush_cnt  out  CNT_W  branch flushes, saturating

## Operation
- Hazard (combinational):
  - src_match(d) = (id_src1==d) | (id_two_src & id_src2==d).
  - With fwd_en=0: hazard = (exe_wb_en & src_match(exe_dest)) | (mem_wb_en & src_match(mem_dest)).
  - With fwd_en=1: hazard = exe_mem_r_en & src_match(exe_dest). This covers load-use only.
- Memory FSM, states RUN, WAIT, RELEASE; down-counter wcnt is 4 bits.
  - RUN: if (mem_r_en|mem_w_en) and MEM_WAIT>0, then freeze_req=1 and wcnt<=MEM_WAIT-1. Next state is RELEASE if MEM_WAIT==1, otherwise WAIT.
  - WAIT: freeze_req=1 and wcnt<=wcnt-1. When wcnt==1, next state is RELEASE.
  - RELEASE: freeze_req=0, the pipeline advances, and the access request is ignored. Next state is RUN.
  - MEM_WAIT=0: the FSM stays in RUN and freeze_req is never asserted.
- Output priority, highest first:
  1. freeze_req: pipe_freeze=pc_freeze=if_id_freeze=1, and if_id_flush=id_exe_clr=0. A branch or hazard present in this cycle is deferred because EXE is held.
  2. exe_branch: if_id_flush=1, id_exe_clr=1, and both freezes are 0. Any hazard is discarded.
  3. hazard: pc_freeze=if_id_freeze=1 and id_exe_clr=1.
  4. Otherwise all outputs are 0.
- Counters:
  - stall_cnt increments in each cycle where case 3 applies.
  - flush_cnt increments in each cycle where case 2 applies.
  - Both saturate at all-ones.

## Timing
- Reset: state=RUN, wcnt=0, stall_cnt=flush_cnt=0. While rst is high, all control outputs are 0.
- Control outputs are combinational from the current inputs and state, so they take effect at the next clk edge. Latency from condition to stage-register response is 0 cycles.
- One SRAM access occupies MEM for MEM_WAIT+1 cycles: MEM_WAIT frozen cycles plus 1 RELEASE cycle.
- Back-to-back accesses: RELEASE is followed by RUN, and the next access re-triggers there. Two adjacent loads therefore take 2×(MEM_WAIT+1) cycles.
- rst asserted mid-WAIT returns the FSM to RUN immediately. pipe_freeze drops in the same cycle.
- A load-use hazard produces exactly one bubble with fwd_en=1. With fwd_en=0, a producer in EXE produces up to 2 bubbles.

## Test plan
- Reset during WAIT: with MEM_WAIT=3, trigger an access, then pulse rst on the 2nd frozen cycle -> all outputs are 0, the state is RUN, and both counters are 0.
- Load-use: fwd_en=1, exe_mem_r_en=1, exe_wb_en=1, exe_dest=4, id_src1=4 -> pc_freeze=if_id_freeze=id_exe_clr=1 for 1 cycle and stall_cnt=1. With id_src1=5 and id_two_src=0 -> no stall.
- No forwarding: fwd_en=0, mem_wb_en=1, mem_dest=7, id_two_src=1, id_src2=7 -> stall is asserted. With id_two_src=0 -> stall is deasserted.
- Branch over hazard: exe_branch=1 and a hazard in the same cycle -> if_id_flush=id_exe_clr=1, pc_freeze=0, flush_cnt=1, stall_cnt unchanged.
- SRAM wait: MEM_WAIT=3, mem_r_en held high for 2 consecutive instructions -> pipe_freeze pattern 1,1,1,0,1,1,1,0. With MEM_WAIT=0 -> pipe_freeze stays at 0.
- Saturation: CNT_W=4, 20 hazard cycles -> stall_cnt holds at 15.
